// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook-time countdown engine.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SEC_10  = 10;
  localparam int unsigned SEC_30  = 30;
  localparam int unsigned SEC_60  = 60;
  localparam int unsigned MAX_SEC = 3599;

  // One-cycle command pulses from the state controller, gathered in one word.
  typedef struct packed {
    logic clear;
    logic start;
    logic pause;
    logic resume;
    logic set_30;
    logic add_1min;
    logic add_10;
  } cmd_t;

  // Add with a ceiling; done in 32 bits so the sum itself can never wrap.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max);
    int unsigned s;
    s = a + b;
    return (s > max) ? max : s;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Sub-second prescaler: one tick every TICKS_PER_SEC enabled cycles.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CW-1:0] cnt;

  // Terminal count is only meaningful while counting is allowed.
  assign tick = enable && (cnt == CW'(TICKS_PER_SEC - 1));

  // Count 0..TICKS_PER_SEC-1 and wrap; hold the value when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/cook_timer.sv
// Countdown engine: executes controller commands, counts seconds down in RUN.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MAX_SEC       = cook_timer_pkg::MAX_SEC,
  parameter int W             = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         add_10sec,
  input  logic         add_1min,
  input  logic         set_30sec,
  input  logic         start_timer,
  input  logic         pause_timer,
  input  logic         resume_timer,
  input  logic         clear_timer,
  output logic [W-1:0] set_time_sec,
  output logic [W-1:0] remaining_sec,
  output logic         timer_completed,
  output logic         timer_running,
  output logic         sec_tick
);
  import cook_timer_pkg::*;

  state_t       state, state_n;
  cmd_t         cmd;
  logic [W-1:0] set_n, rem_n;
  logic         cmp_n, tick_n;
  logic         psc_en, psc_clr, psc_tick;
  int unsigned  add_amt;

  assign cmd = '{clear: clear_timer, start: start_timer, pause: pause_timer,
                 resume: resume_timer, set_30: set_30sec, add_1min: add_1min,
                 add_10: add_10sec};

  // A pause (or clear) in the same cycle as the terminal count suppresses it.
  assign psc_en = (state == RUN) && !cmd.pause && !cmd.clear;

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_psc (
    .clk    (clk),
    .reset  (reset),
    .enable (psc_en),
    .clear  (psc_clr),
    .tick   (psc_tick)
  );

  // Next-state and next-output decode, highest-priority valid command first.
  always_comb begin
    state_n = state;
    set_n   = set_time_sec;
    rem_n   = remaining_sec;
    cmp_n   = 1'b0;
    tick_n  = 1'b0;
    psc_clr = 1'b0;
    add_amt = (cmd.add_10 ? SEC_10 : 0) + (cmd.add_1min ? SEC_60 : 0);
    if (cmd.clear) begin
      state_n = STOP;
      set_n   = '0;
      rem_n   = '0;
      psc_clr = 1'b1;
    end else begin
      unique case (state)
        STOP: begin
          if (cmd.start && cmd.set_30 && set_time_sec == '0) begin
            // double-click: quick-set and go in one step
            set_n   = W'(SEC_30);
            rem_n   = W'(SEC_30);
            state_n = RUN;
            psc_clr = 1'b1;
          end else if (cmd.start && set_time_sec != '0) begin
            rem_n   = set_time_sec;
            state_n = RUN;
            psc_clr = 1'b1;
          end else if (cmd.set_30 && set_time_sec == '0) begin
            set_n = W'(SEC_30);
          end else if (add_amt != 0) begin
            set_n = W'(sat_add(32'(set_time_sec), add_amt, MAX_SEC));
          end
        end
        RUN: begin
          if (cmd.pause) begin
            state_n = PAUSE;
          end else if (psc_tick) begin
            tick_n = 1'b1;
            rem_n  = remaining_sec - W'(1);
            if (remaining_sec == W'(1)) begin
              cmp_n   = 1'b1;
              set_n   = '0;
              state_n = DONE;
            end
          end
        end
        PAUSE: begin
          if (cmd.resume) begin
            state_n = (remaining_sec != '0) ? RUN : STOP;
          end else if (add_amt != 0) begin
            set_n = W'(sat_add(32'(set_time_sec), add_amt, MAX_SEC));
            rem_n = W'(sat_add(32'(remaining_sec), add_amt, MAX_SEC));
          end
        end
        DONE: begin
          state_n = STOP;
          set_n   = '0;
          rem_n   = '0;
        end
        default: state_n = STOP;
      endcase
    end
  end

  // All outputs registered so each command shows up the cycle after its pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= STOP;
      set_time_sec    <= '0;
      remaining_sec   <= '0;
      timer_completed <= 1'b0;
      timer_running   <= 1'b0;
      sec_tick        <= 1'b0;
    end else begin
      state           <= state_n;
      set_time_sec    <= set_n;
      remaining_sec   <= rem_n;
      timer_completed <= cmp_n;
      timer_running   <= (state_n == RUN);
      sec_tick        <= tick_n;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Scoreboard bench for cook_timer: each applied command pushes its expected
// registered outputs; they are popped and compared one negedge later.
module tb_cook_timer;
  localparam int T = 10;
  localparam int W = 12;

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] ADD10  = 7'b0000001;
  localparam logic [6:0] ADD1M  = 7'b0000010;
  localparam logic [6:0] SET30  = 7'b0000100;
  localparam logic [6:0] RESUME = 7'b0001000;
  localparam logic [6:0] PAUSE  = 7'b0010000;
  localparam logic [6:0] START  = 7'b0100000;
  localparam logic [6:0] CLEAR  = 7'b1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic add_10sec = 1'b0, add_1min = 1'b0, set_30sec = 1'b0, start_timer = 1'b0;
  logic pause_timer = 1'b0, resume_timer = 1'b0, clear_timer = 1'b0;
  logic [W-1:0] set_time_sec, remaining_sec;
  logic timer_completed, timer_running, sec_tick;

  cook_timer #(.TICKS_PER_SEC(T), .MAX_SEC(3599), .W(W)) dut (
    .clk(clk), .reset(reset),
    .add_10sec(add_10sec), .add_1min(add_1min), .set_30sec(set_30sec),
    .start_timer(start_timer), .pause_timer(pause_timer),
    .resume_timer(resume_timer), .clear_timer(clear_timer),
    .set_time_sec(set_time_sec), .remaining_sec(remaining_sec),
    .timer_completed(timer_completed), .timer_running(timer_running),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [W-1:0] st, rm;
    logic         run, cmp, tk;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] stim_q[$];
  exp_t       e;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic exp_t mk(string nm, int st, int rm, logic run, logic cmp, logic tk);
    exp_t x;
    x.nm = nm; x.st = W'(st); x.rm = W'(rm); x.run = run; x.cmp = cmp; x.tk = tk;
    return x;
  endfunction

  // Queue one command together with the outputs it must produce.
  task automatic sched(input logic [6:0] c, input exp_t x);
    stim_q.push_back(c);
    exp_q.push_back(x);
  endtask

  // Called at a negedge: drive command, advance to the next negedge, release.
  task automatic apply(input logic [6:0] c);
    {clear_timer, start_timer, pause_timer, resume_timer, set_30sec, add_1min, add_10sec} = c;
    @(negedge clk);
    {clear_timer, start_timer, pause_timer, resume_timer, set_30sec, add_1min, add_10sec} = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back(mk("reset_por", 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
      miscompares++;
      $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
    end
    reset = 1'b0;
    sched(ADD10, mk("reset_setup", 10, 0, 0, 0, 0));
    sched(ADD10, mk("reset_setup", 20, 0, 0, 0, 0));
    sched(START, mk("reset_start", 20, 20, 1, 0, 0));
    for (int i = 1; i <= 3*T; i++)
      sched(IDLE, mk("reset_run", 20, 20 - i/T, 1, 0, (i % T) == 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
    // remaining is 17 here; reset lands between clock edges
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(mk("reset_async", 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
      miscompares++;
      $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2*T + 2; i++)
      sched(IDLE, mk("reset_idle", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
  endtask

  task automatic test_run70();
    int ticks = 0;
    int comps = 0;
    sched(ADD1M, mk("run70_add1m", 60, 0, 0, 0, 0));
    sched(ADD10, mk("run70_add10", 70, 0, 0, 0, 0));
    sched(START, mk("run70_start", 70, 70, 1, 0, 0));
    for (int i = 1; i <= 70*T; i++)
      sched(IDLE, mk("run70_count", (i < 70*T) ? 70 : 0, 70 - i/T, i < 70*T, i == 70*T, (i % T) == 0));
    sched(IDLE, mk("run70_stop", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      ticks += int'(sec_tick);
      comps += int'(timer_completed);
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
    vectors++;
    if (ticks != 70 || comps != 1) begin
      miscompares++;
      $display("FAIL run70_totals: got ticks=%0d completes=%0d, want ticks=70 completes=1", ticks, comps);
    end
  endtask

  task automatic test_double_click();
    sched(SET30 | START, mk("dclick_start", 30, 30, 1, 0, 0));
    for (int i = 1; i <= T; i++)
      sched(IDLE, mk("dclick_run", 30, 30 - i/T, 1, 0, i == T));
    sched(CLEAR, mk("dclick_clear", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
  endtask

  task automatic test_pause_resume();
    sched(ADD10, mk("pr_add", 10, 0, 0, 0, 0));
    sched(START, mk("pr_start", 10, 10, 1, 0, 0));
    // after 5T+6 cycles: remaining 5, prescaler holding 6
    for (int i = 1; i <= 5*T + 6; i++)
      sched(IDLE, mk("pr_run", 10, 10 - i/T, 1, 0, (i % T) == 0));
    sched(PAUSE, mk("pr_pause", 10, 5, 0, 0, 0));
    for (int i = 0; i < 100; i++)
      sched(IDLE, mk("pr_hold", 10, 5, 0, 0, 0));
    sched(ADD10, mk("pr_add_paused", 20, 15, 0, 0, 0));
    sched(RESUME, mk("pr_resume", 20, 15, 1, 0, 0));
    for (int j = 1; j <= T - 6; j++)
      sched(IDLE, mk("pr_after_resume", 20, (j == T - 6) ? 14 : 15, 1, 0, j == T - 6));
    sched(CLEAR, mk("pr_clear", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 59; k++)
      sched(ADD1M, mk("sat_add1m", 60*k, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      sched(ADD10, mk("sat_add10", 3540 + 10*k, 0, 0, 0, 0));
    sched(ADD10 | ADD1M, mk("sat_both", 3599, 0, 0, 0, 0));
    sched(ADD10, mk("sat_again", 3599, 0, 0, 0, 0));
    sched(CLEAR, mk("sat_clear", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
  endtask

  task automatic test_clear_final();
    sched(ADD10, mk("cf_add", 10, 0, 0, 0, 0));
    sched(START, mk("cf_start", 10, 10, 1, 0, 0));
    // stop one cycle short of the final tick: remaining 1, prescaler terminal
    for (int i = 1; i <= 10*T - 1; i++)
      sched(IDLE, mk("cf_run", 10, 10 - i/T, 1, 0, (i % T) == 0));
    sched(CLEAR, mk("cf_clear", 0, 0, 0, 0, 0));
    for (int i = 0; i < 2*T; i++)
      sched(IDLE, mk("cf_quiet", 0, 0, 0, 0, 0));
    sched(START, mk("cf_start_ignored", 0, 0, 0, 0, 0));
    for (int i = 0; i < T; i++)
      sched(IDLE, mk("cf_stays_stop", 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front(); vectors++;
      if ({set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick} !== {e.st, e.rm, e.run, e.cmp, e.tk}) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rm=%0d run/cmp/tk=%b%b%b, want st=%0d rm=%0d run/cmp/tk=%b%b%b", e.nm, set_time_sec, remaining_sec, timer_running, timer_completed, sec_tick, e.st, e.rm, e.run, e.cmp, e.tk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run70();
    test_double_click();
    test_pause_resume();
    test_saturate();
    test_clear_final();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
